// File: rtl/motor_status_debouncer_pkg.sv
// Shared motor-controller types: the per-motor status word and fiber sizing.
package MCPkg;

    localparam int NUMBER_OF_MOTORS_PER_FIBER = 16;

    typedef struct packed {
        logic       OH_i;
        logic       StepPFail_i;
        logic [1:0] RawSwitches_b2;
    } motorsStatuses_t;

    localparam int MOTOR_STATUS_BITS = $bits(motorsStatuses_t);

endpackage

// File: rtl/motor_status_debouncer_debounce_cell.sv
// One status bit: 2-FF synchroniser, tick-sampled stable counter, debounced output
// and a one-cycle toggle pulse registered alongside the output change.
module debounce_cell #(
    parameter int g_StableTicks = 5
) (
    input  logic Clk_ik,
    input  logic Reset_iran,
    input  logic Tick_i,
    input  logic Raw_i,
    output logic Debounced_o,
    output logic Toggle_o
);

    localparam int CNT_W = $clog2(g_StableTicks + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(g_StableTicks - 1);

    logic             sync_meta;
    logic             sync_bit;
    logic [CNT_W-1:0] stable_cnt;

    // Any equal sample restarts the count, so only an uninterrupted run of differing samples flips the output.
    always_ff @(posedge Clk_ik or negedge Reset_iran) begin
        if (!Reset_iran) begin
            sync_meta   <= 1'b0;
            sync_bit    <= 1'b0;
            stable_cnt  <= '0;
            Debounced_o <= 1'b0;
            Toggle_o    <= 1'b0;
        end else begin
            sync_meta <= Raw_i;
            sync_bit  <= sync_meta;
            Toggle_o  <= 1'b0;
            if (Tick_i) begin
                if (sync_bit == Debounced_o) begin
                    stable_cnt <= '0;
                end else if (stable_cnt == LAST_COUNT) begin
                    Debounced_o <= ~Debounced_o;
                    Toggle_o    <= 1'b1;
                    stable_cnt  <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/motor_status_debouncer.sv
// Debounces every status bit of all motors on one fiber; the tick divider is shared
// by all cells and per-motor sticky flags record debounced transitions.
module motor_status_debouncer
    import MCPkg::*;
#(
    parameter int g_NumMotors   = NUMBER_OF_MOTORS_PER_FIBER,
    parameter int g_TickDivider = 40000,
    parameter int g_StableTicks = 5
) (
    input  logic                           Clk_ik,
    input  logic                           Reset_iran,
    input  motorsStatuses_t [1:g_NumMotors] RawStatus_ib,
    input  logic [g_NumMotors:1]           ClearChanged_ib,
    output motorsStatuses_t [1:g_NumMotors] debounced_motorStatus_ob,
    output logic [g_NumMotors:1]           Changed_ob,
    output logic                           Tick_o
);

    localparam int TICK_W = $clog2(g_TickDivider);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(g_TickDivider - 1);

    if (MOTOR_STATUS_BITS != 4) begin : g_bad_status_width
        $error("motorsStatuses_t must be exactly 4 bits wide");
    end

    logic [TICK_W-1:0]                          tick_cnt;
    logic [1:g_NumMotors][MOTOR_STATUS_BITS-1:0] raw_flat;
    logic [1:g_NumMotors][MOTOR_STATUS_BITS-1:0] debounced_flat;
    logic [1:g_NumMotors][MOTOR_STATUS_BITS-1:0] motor_toggle;

    assign raw_flat                 = RawStatus_ib;
    assign debounced_motorStatus_ob = debounced_flat;
    assign Tick_o                   = (tick_cnt == TICK_LAST);

    always_ff @(posedge Clk_ik or negedge Reset_iran) begin
        if (!Reset_iran) begin
            tick_cnt <= '0;
        end else if (Tick_o) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar m = 1; m <= g_NumMotors; m++) begin : g_motor
        for (genvar b = 0; b < MOTOR_STATUS_BITS; b++) begin : g_bit
            debounce_cell #(
                .g_StableTicks(g_StableTicks)
            ) u_cell (
                .Clk_ik      (Clk_ik),
                .Reset_iran  (Reset_iran),
                .Tick_i      (Tick_o),
                .Raw_i       (raw_flat[m][b]),
                .Debounced_o (debounced_flat[m][b]),
                .Toggle_o    (motor_toggle[m][b])
            );
        end
    end

    // A toggle in the same cycle as a clear must not be lost, so set takes priority.
    always_ff @(posedge Clk_ik or negedge Reset_iran) begin
        if (!Reset_iran) begin
            Changed_ob <= '0;
        end else begin
            for (int m = 1; m <= g_NumMotors; m++) begin
                if (|motor_toggle[m]) begin
                    Changed_ob[m] <= 1'b1;
                end else if (ClearChanged_ib[m]) begin
                    Changed_ob[m] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_status_debouncer.sv
// Directed bench for motor_status_debouncer with a 4-cycle tick and 3 stable ticks.
module tb_motor_status_debouncer;
    import MCPkg::*;

    localparam int NUM_MOTORS = 16;
    localparam int TICK_DIV   = 4;
    localparam int STABLE     = 3;

    logic                          ClkRxGBT_x = 1'b0;
    logic                          reset_n    = 1'b0;
    motorsStatuses_t [1:NUM_MOTORS] raw_status;
    logic [NUM_MOTORS:1]           clear_changed;
    motorsStatuses_t [1:NUM_MOTORS] deb_status;
    logic [NUM_MOTORS:1]           changed;
    logic                          tick;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 ClkRxGBT_x = ~ClkRxGBT_x;

    motor_status_debouncer #(
        .g_NumMotors   (NUM_MOTORS),
        .g_TickDivider (TICK_DIV),
        .g_StableTicks (STABLE)
    ) dut (
        .Clk_ik                   (ClkRxGBT_x),
        .Reset_iran               (reset_n),
        .RawStatus_ib             (raw_status),
        .ClearChanged_ib          (clear_changed),
        .debounced_motorStatus_ob (deb_status),
        .Changed_ob               (changed),
        .Tick_o                   (tick)
    );

    // Leaves the caller at the falling edge on which reset was released; no rising edge seen yet.
    task automatic apply_reset();
        @(negedge ClkRxGBT_x);
        reset_n       = 1'b0;
        clear_changed = '0;
        repeat (2) @(negedge ClkRxGBT_x);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        raw_status    = {NUM_MOTORS{4'hF}};
        clear_changed = '0;
        @(negedge ClkRxGBT_x);
        reset_n = 1'b0;
        repeat (2) @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %h expected %h", deb_status, 64'h0);
        end
        tests_run++;
        if (changed !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_changed: got %h expected %h", changed, 16'h0);
        end
        tests_run++;
        if (tick !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_tick: got %b expected %b", tick, 1'b0);
        end
        reset_n = 1'b1;
        repeat (11) @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_early_status: got %h expected %h", deb_status, 64'h0);
        end
        @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_converged_status: got %h expected %h", deb_status, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        tests_run++;
        if (changed !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_changed_lag: got %h expected %h", changed, 16'h0);
        end
        @(negedge ClkRxGBT_x);
        tests_run++;
        if (changed !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_changed_set: got %h expected %h", changed, 16'hFFFF);
        end
    endtask

    task automatic test_tick_period();
        logic exp_tick;
        raw_status = '0;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge ClkRxGBT_x);
            exp_tick = ((k % TICK_DIV) == TICK_DIV - 1);
            tests_run++;
            if (tick !== exp_tick) begin
                tests_failed++;
                $display("[TB] FAIL tick_period[%0d]: got %b expected %b", k, tick, exp_tick);
            end
        end
    endtask

    task automatic test_glitch();
        for (int ph = 0; ph < TICK_DIV; ph++) begin
            raw_status = '0;
            apply_reset();
            repeat (3 + ph) @(negedge ClkRxGBT_x);
            raw_status[5] = 4'h1;
            repeat (2 * TICK_DIV) @(negedge ClkRxGBT_x);
            raw_status[5] = 4'h0;
            repeat (20) @(negedge ClkRxGBT_x);
            tests_run++;
            if (deb_status !== 64'h0) begin
                tests_failed++;
                $display("[TB] FAIL glitch_status[ph%0d]: got %h expected %h", ph, deb_status, 64'h0);
            end
            tests_run++;
            if (changed[5] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL glitch_changed5[ph%0d]: got %b expected %b", ph, changed[5], 1'b0);
            end
        end
    endtask

    // Raw edge lands in the cycle before a tick, which is the worst case: 2 + 4*3 = 14 edges.
    task automatic test_clean_edge();
        bit found = 0;
        raw_status = '0;
        apply_reset();
        for (int i = 0; i < 2 * TICK_DIV && !found; i++) begin
            @(negedge ClkRxGBT_x);
            if (tick === 1'b1) found = 1;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL clean_edge_tick_timeout: got no tick expected one within %0d cycles", 2 * TICK_DIV);
        end
        repeat (TICK_DIV - 1) @(negedge ClkRxGBT_x);
        raw_status[16] = 4'b0010;
        repeat (13) @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status[16] !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL clean_edge_early: got %h expected %h", deb_status[16], 4'b0000);
        end
        @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status[16] !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL clean_edge_output: got %h expected %h", deb_status[16], 4'b0010);
        end
        tests_run++;
        if (changed !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL clean_edge_changed_lag: got %h expected %h", changed, 16'h0000);
        end
        @(negedge ClkRxGBT_x);
        tests_run++;
        if (changed !== 16'h8000) begin
            tests_failed++;
            $display("[TB] FAIL clean_edge_changed: got %h expected %h", changed, 16'h8000);
        end
    endtask

    task automatic test_clear_priority();
        raw_status    = '0;
        raw_status[3] = 4'h1;
        apply_reset();
        repeat (12) @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status[3] !== 4'h1) begin
            tests_failed++;
            $display("[TB] FAIL clear_toggle_output: got %h expected %h", deb_status[3], 4'h1);
        end
        clear_changed[3] = 1'b1;
        @(negedge ClkRxGBT_x);
        clear_changed[3] = 1'b0;
        tests_run++;
        if (changed !== 16'h0004) begin
            tests_failed++;
            $display("[TB] FAIL clear_set_wins: got %h expected %h", changed, 16'h0004);
        end
        repeat (2) @(negedge ClkRxGBT_x);
        tests_run++;
        if (changed[3] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clear_sticky: got %b expected %b", changed[3], 1'b1);
        end
        clear_changed[3] = 1'b1;
        @(negedge ClkRxGBT_x);
        clear_changed[3] = 1'b0;
        tests_run++;
        if (changed[3] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL clear_alone: got %b expected %b", changed[3], 1'b0);
        end
    endtask

    task automatic test_reset_mid_count();
        raw_status    = '0;
        raw_status[1] = 4'h1;
        apply_reset();
        repeat (9) @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status[1] !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_before: got %h expected %h", deb_status[1], 4'h0);
        end
        reset_n = 1'b0;
        @(negedge ClkRxGBT_x);
        reset_n = 1'b1;
        repeat (4) @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status[1] !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_first_tick: got %h expected %h", deb_status[1], 4'h0);
        end
        repeat (7) @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status[1] !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_early: got %h expected %h", deb_status[1], 4'h0);
        end
        @(negedge ClkRxGBT_x);
        tests_run++;
        if (deb_status[1] !== 4'h1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_output: got %h expected %h", deb_status[1], 4'h1);
        end
    endtask

    initial begin
        raw_status    = '0;
        clear_changed = '0;
        test_reset();
        test_tick_period();
        test_glitch();
        test_clean_edge();
        test_clear_priority();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
